// File: rtl/pipe_pkg.sv
// Shared definitions for the decode->execute pipeline register stage.
package pipe_pkg;

    localparam int unsigned PAYLOAD_W_DEF = 128;
    localparam int unsigned CTRL_W_DEF    = 12;
    localparam int unsigned OCC_W         = 2;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: payload register plus valid bit.
// Clearing the low control bits turns a stale entry into a NOP.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int unsigned CTRL_W    = CTRL_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 clr_ctrl_i,
    input  logic                 valid_d_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q;
    logic [PAYLOAD_W-1:0] payload_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q <= valid_d_i;
            if (clr_ctrl_i) begin
                payload_q[CTRL_W-1:0] <= '0;
            end else if (load_i) begin
                payload_q <= payload_i;
            end
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/pipe_stage.sv
// Two-slot (main + skid) pipeline register with registered in_ready.
// Define PIPE_STAGE_STATS_EN to enable the saturating stall/bubble counters.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int unsigned CTRL_W    = CTRL_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [OCC_W-1:0]     occupancy,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
);

    state_e               state_q, state_d;
    logic                 in_ready_q;
    logic                 in_xfer, out_xfer;
    logic                 main_load, main_clr, main_valid_d, main_valid;
    logic                 skid_load, skid_clr, skid_valid_d, skid_valid;
    logic [PAYLOAD_W-1:0] main_din, main_payload, skid_payload;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_load    = 1'b0;
        main_clr     = 1'b0;
        main_valid_d = main_valid;
        main_din     = in_payload;
        skid_load    = 1'b0;
        skid_clr     = 1'b0;
        skid_valid_d = skid_valid;
        if (flush) begin
            state_d      = EMPTY;
            main_clr     = 1'b1;
            skid_clr     = 1'b1;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load    = 1'b1;
                        main_valid_d = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        // Head leaves with nothing behind it: scrub control to a NOP.
                        main_valid_d = 1'b0;
                        main_clr     = 1'b1;
                        state_d      = EMPTY;
                    end else if (in_xfer) begin
                        skid_load    = 1'b1;
                        skid_valid_d = 1'b1;
                        state_d      = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_load    = 1'b1;
                        main_din     = skid_payload;
                        skid_valid_d = 1'b0;
                        skid_clr     = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (main_load),
        .clr_ctrl_i (main_clr),
        .valid_d_i  (main_valid_d),
        .payload_i  (main_din),
        .valid_o    (main_valid),
        .payload_o  (main_payload)
    );

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_skid (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (skid_load),
        .clr_ctrl_i (skid_clr),
        .valid_d_i  (skid_valid_d),
        .payload_i  (in_payload),
        .valid_o    (skid_valid),
        .payload_o  (skid_payload)
    );

    always_comb begin
        unique case (state_q)
            ONE:     occupancy = OCC_W'(1);
            FULL:    occupancy = OCC_W'(2);
            default: occupancy = '0;
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid;
    assign out_payload = main_payload;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q, bubble_q;

    // Counters survive flush; only RESET clears them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_valid && !out_ready && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!main_valid && bubble_q != '1) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios then random traffic,
// compared against a queue-based model of the stage's ordering and NOP rules.
module tb_pipe_stage;

    localparam int W = 128;
    localparam int C = 12;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_payload = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_payload;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;

    pipe_stage #(.PAYLOAD_W(W), .CTRL_W(C)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 CLK = ~CLK;

    logic [W-1:0] q[$];
    logic [W-1:0] last_head;
    logic [W-1:0] ctrl_mask;
    logic [31:0]  m_stall, m_bubble;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] exp_pay;
        exp_pay = (q.size() > 0) ? q[0] : (last_head & ~ctrl_mask);
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("out_payload", out_payload, exp_pay);
        chk("in_ready", W'(in_ready), W'(q.size() < 2));
        chk("occupancy", W'(occupancy), W'(q.size()));
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt", W'(stall_cnt), W'(m_stall));
        chk("bubble_cnt", W'(bubble_cnt), W'(m_bubble));
`else
        chk("stall_cnt", W'(stall_cnt), '0);
        chk("bubble_cnt", W'(bubble_cnt), '0);
`endif
    endtask

    // One clock edge of the reference: FIFO of depth 2, flush empties it.
    task automatic model_step();
        bit iv, ov;
        iv = in_valid && (q.size() < 2);
        ov = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall++;
        end else if (q.size() == 0) begin
            if (m_bubble != 32'hFFFF_FFFF) m_bubble++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (ov) void'(q.pop_front());
            if (iv) q.push_back(in_payload);
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        @(negedge CLK);
        in_valid   = iv;
        in_payload = d;
        out_ready  = ordy;
        flush      = fl;
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2 RESET = 1'b1;
        #1;
        q.delete();
        last_head = '0;
        m_stall   = '0;
        m_bubble  = '0;
        check_all();
        #1 RESET = 1'b0;
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_mask = '0;
        for (int i = 0; i < C; i++) ctrl_mask[i] = 1'b1;
        last_head = '0;
        m_stall   = '0;
        m_bubble  = '0;

        do_reset();

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_valid", W'(out_valid), W'(1));
            chk("stream_data", out_payload, W'(i));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B fill both slots, C must wait upstream.
        cycle(1'b1, W'('hA), 1'b0, 1'b0);
        cycle(1'b1, W'('hB), 1'b0, 1'b0);
        chk("bp_full_occ", W'(occupancy), W'(2));
        chk("bp_full_rdy", W'(in_ready), '0);
        cycle(1'b1, W'('hC), 1'b0, 1'b0);
        cycle(1'b1, W'('hC), 1'b1, 1'b0);
        chk("bp_head_b", out_payload, W'('hB));
        cycle(1'b1, W'('hC), 1'b1, 1'b0);
        chk("bp_head_c", out_payload, W'('hC));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush from FULL with a pending input, then from ONE.
        cycle(1'b1, W'('hA), 1'b0, 1'b0);
        cycle(1'b1, W'('hB), 1'b0, 1'b0);
        cycle(1'b1, W'('hC), 1'b0, 1'b1);
        chk("flush_valid", W'(out_valid), '0);
        chk("flush_ctrl", out_payload & ctrl_mask, '0);
        chk("flush_rdy", W'(in_ready), W'(1));
        cycle(1'b1, W'('hD), 1'b0, 1'b0);
        cycle(1'b1, W'('hE), 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous in/out while holding one entry.
        cycle(1'b1, W'('h11), 1'b1, 1'b0);
        cycle(1'b1, W'('h22), 1'b1, 1'b0);
        chk("simul_head", out_payload, W'('h22));
        chk("simul_occ", W'(occupancy), W'(1));

        // Mid-transfer reset with both slots held.
        cycle(1'b1, W'('h33), 1'b0, 1'b0);
        do_reset();

        // Statistics: 3 empty cycles then 5 stalled cycles.
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, rnd(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_stall", W'(stall_cnt), W'(5));
        chk("stats_bubble", W'(bubble_cnt), W'(3));
`else
        chk("stats_stall", W'(stall_cnt), '0);
        chk("stats_bubble", W'(bubble_cnt), '0);
`endif

        // Random traffic with occasional flush and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle($urandom_range(9, 0) < 7, rnd(), $urandom_range(9, 0) < 6,
                  $urandom_range(19, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
